// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Borrows the shared 8-bit ALU to form the low byte of op_a * op_b by
// shift-and-add. Each iteration takes three ALU cycles: conditional add of
// the multiplicand into the accumulator, shift the multiplicand left, and
// shift the multiplier right. Signed and unsigned operands give the same
// low byte, so no sign handling is needed.
//
// Optional feature: define ALU_SEQ_EARLY_EXIT_EN to finish as soon as the
// shifted multiplier reaches zero (ALU Z flag in the SHR step). When it is
// undefined every operation runs all eight iterations. The product is the
// same in both builds.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin multiply; only sampled in IDLE/DONE
//   op_a      in   [7:0] multiplicand, captured on accepted start
//   op_b      in   [7:0] multiplier, captured on accepted start
//   alu_gnt   in   ALU granted to this block this cycle
//   result    in   [7:0] ALU combinational result
//   n         in   ALU negative flag (not used)
//   z         in   ALU zero flag (used only with early exit)
//   alu_req   out  ALU requested (ADD/SHL/SHR)
//   alu_op    out  [2:0] ALU opcode
//   src_a     out  [7:0] ALU operand A
//   src_b     out  [7:0] ALU operand B
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   product   out  [7:0] low byte of op_a*op_b, held until the next result
//
// state  | meaning
// IDLE   | waiting for start
// ADD    | acc <- acc + a when b[0] is set
// SHL    | a <- a << 1
// SHR    | b <- b >> 1, count iteration, decide loop or finish
// DONE   | done pulse; product already registered
module alu_mul_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       alu_gnt,
  input  logic [7:0] result,
  input  logic       n,
  input  logic       z,
  output logic       alu_req,
  output logic [2:0] alu_op,
  output logic [7:0] src_a,
  output logic [7:0] src_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  // ALU opcode encoding shared with the datapath: ADD=0, SUB=1, AND=2, SLL=3, SRL=4.
  localparam logic [2:0] K_ADD = 3'd0;
  localparam logic [2:0] K_SLL = 3'd3;
  localparam logic [2:0] K_SRL = 3'd4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_SHL  = 3'd2;
  localparam logic [2:0] S_SHR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state;
  logic [7:0] acc;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] cnt;
  logic       early_exit;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  // Z in SHR means the multiplier just shifted to zero: nothing left to add.
  assign early_exit = z;
`else
  assign early_exit = 1'b0;
`endif

  logic unused_flags;
  assign unused_flags = n ^ z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      a       <= '0;
      b       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc   <= '0;
            a     <= op_a;
            b     <= op_b;
            cnt   <= '0;
            state <= S_ADD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADD: begin
          if (alu_gnt) begin
            if (b[0]) acc <= result;
            state <= S_SHL;
          end
        end
        S_SHL: begin
          if (alu_gnt) begin
            a     <= result;
            state <= S_SHR;
          end
        end
        S_SHR: begin
          if (alu_gnt) begin
            b   <= result;
            cnt <= cnt + 3'd1;
            // acc is final here: this iteration's add already happened.
            if (cnt == 3'd7 || early_exit) begin
              product <= acc;
              state   <= S_DONE;
            end else begin
              state <= S_ADD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_req = 1'b0;
    alu_op  = K_ADD;
    src_a   = '0;
    src_b   = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_ADD: begin
        alu_req = 1'b1;
        busy    = 1'b1;
        alu_op  = K_ADD;
        src_a   = acc;
        src_b   = a;
      end
      S_SHL: begin
        alu_req = 1'b1;
        busy    = 1'b1;
        alu_op  = K_SLL;
        src_a   = a;
        src_b   = 8'd1;
      end
      S_SHR: begin
        alu_req = 1'b1;
        busy    = 1'b1;
        alu_op  = K_SRL;
        src_a   = b;
        src_b   = 8'd1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: models the shared ALU, drives directed and
// random multiplies with stalls, ignored start pulses and back-to-back
// starts, and compares against products and latencies computed from
// plain arithmetic.
module tb_alu_mul_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       alu_gnt = 1'b1;
  logic [7:0] op_a = 8'd0;
  logic [7:0] op_b = 8'd0;
  logic [7:0] result;
  logic       n;
  logic       z;
  logic       alu_req;
  logic [2:0] alu_op;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_product = 8'd0;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .alu_gnt (alu_gnt),
    .result  (result),
    .n       (n),
    .z       (z),
    .alu_req (alu_req),
    .alu_op  (alu_op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Shared ALU: ADD=0, SUB=1, AND=2, SLL=3, SRL=4.
  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x << y[2:0];
      3'd4: return x >> y[2:0];
      default: return 8'd0;
    endcase
  endfunction

  assign result = alu_model(alu_op, src_a, src_b);
  assign z      = (result == 8'd0);
  assign n      = result[7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle (counting the first ADD cycle as 1) in which done appears, no stalls.
  function automatic int expected_latency(input logic [7:0] b);
    int k;
    k = 8;
    if (EARLY) begin
      k = 1;
      for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
    end
    return 3 * k + 1;
  endfunction

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    op_a  = x;
    op_b  = y;
  endtask

  // Expects issue() to have been called before the accepting edge. Returns
  // at the negedge of the done cycle, before the following edge.
  task automatic run(input logic [7:0] x, input logic [7:0] y,
                     input int stall_at, input int stall_len, input int pulse_at);
    int          exp_done;
    logic [15:0] full;
    logic [7:0]  exp_prod;
    exp_done = expected_latency(y) + stall_len;
    full     = 16'(x) * 16'(y);
    exp_prod = full[7:0];
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      start = (cyc == pulse_at);
      if (start) begin
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      alu_gnt = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      chk("busy", busy, cyc < exp_done);
      chk("alu_req", alu_req, cyc < exp_done);
      chk("done", done, cyc == exp_done);
      chk("product", product, (cyc == exp_done) ? exp_prod : last_product);
    end
    start   = 1'b0;
    alu_gnt = 1'b1;
    last_product = exp_prod;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_req", alu_req, 1'b0);
    chk("idle_product", product, last_product);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, alu_req, 1'b0);
    chk({tag, "_op"}, alu_op, 3'd0);
    chk({tag, "_src_a"}, src_a, 8'd0);
    chk({tag, "_src_b"}, src_b, 8'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_product"}, product, 8'd0);
  endtask

  initial begin
    int         base;
    int         s_at;
    int         s_len;
    int         p_at;
    logic [7:0] ra;
    logic [7:0] rb;

    #1;
    chk_reset_outputs("por");
    #12 rst_n = 1'b1;
    @(negedge clk);

    issue(8'd13, 8'd11);  run(8'd13, 8'd11, 0, 0, 0);  idle_cycle();
    issue(8'h80, 8'h7F);  run(8'h80, 8'h7F, 0, 0, 0);  idle_cycle();
    issue(8'hFF, 8'hFF);  run(8'hFF, 8'hFF, 0, 0, 0);
    // back-to-back: start held during the done cycle
    issue(8'd5, 8'd0);    run(8'd5, 8'd0, 0, 0, 0);    idle_cycle();
    issue(8'd13, 8'd11);  run(8'd13, 8'd11, 6, 5, 0);  idle_cycle();
    issue(8'd13, 8'd11);  run(8'd13, 8'd11, 0, 0, 3);  idle_cycle();

    for (int t = 0; t < 12; t++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      base  = expected_latency(rb);
      s_len = $urandom_range(0, 4);
      s_at  = (s_len > 0) ? $urandom_range(1, base - 1) : 0;
      p_at  = $urandom_range(0, base - 1);
      issue(ra, rb);
      run(ra, rb, s_at, s_len, p_at);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    // asynchronous reset in cycle 10 of a run
    issue(8'd13, 8'd11);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_product = 8'd0;
    @(negedge clk);
    chk("post_rst_product", product, 8'd0);
    issue(8'd3, 8'd3);
    run(8'd3, 8'd3, 0, 0, 0);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
